// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C frame arbiter: FSM state encoding,
// frame width, codec address and a frame-assembly function.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_e;

  localparam int         I2C_FRAME_W = 24;
  localparam logic [6:0] CODEC_ADDR  = 7'b0011010;

  // Write frame: {7-bit device address, R/W=0, 7-bit register, 9-bit data}.
  function automatic logic [I2C_FRAME_W-1:0] build_frame(
    input logic [6:0] addr,
    input logic [6:0] reg_addr,
    input logic [8:0] data
  );
    return {addr, 1'b0, reg_addr, data};
  endfunction

endpackage

// File: rtl/i2c_arbiter_if.sv
// Requester and sender handshake bundle around the I2C arbiter.
interface i2c_arbiter_if #(
  parameter int N_REQ   = 2,
  parameter int FRAME_W = i2c_pkg::I2C_FRAME_W
);

  logic [N_REQ-1:0]         i_req;
  logic [N_REQ*FRAME_W-1:0] i_dat;
  logic [N_REQ-1:0]         o_grant;
  logic [N_REQ-1:0]         o_done;
  logic                     o_err;
  logic                     o_busy;
  logic [FRAME_W-1:0]       o_sender_dat;
  logic                     o_sender_start;
  logic                     i_sender_finished;

  modport slave (
    input  i_req, i_dat, i_sender_finished,
    output o_grant, o_done, o_err, o_busy, o_sender_dat, o_sender_start
  );

  modport master (
    output i_req, i_dat, i_sender_finished,
    input  o_grant, o_done, o_err, o_busy, o_sender_dat, o_sender_start
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping modulo N_REQ.
module rr_pick #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx
);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) sum -= N_REQ;
    return IDX_W'(sum);
  endfunction

  // Walk from the farthest offset down so the nearest requester is written last.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latch).
    o_grant = '0;
    o_idx   = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (i_req[wrap_idx(i_ptr, off)]) begin
        o_idx          = wrap_idx(i_ptr, off);
        o_grant        = '0;
        o_grant[o_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C frame sender between N_REQ requesters,
// with completion timeout and an enforced idle gap between transactions.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int FRAME_W        = I2C_FRAME_W,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic          i_clk,
  input logic          i_rst,
  i2c_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic [FRAME_W-1:0] dat_q, dat_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic [N_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               timed_out;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req   (bus.i_req),
    .i_ptr   (ptr_q),
    .o_grant (pick_grant),
    .o_idx   (pick_idx)
  );

  assign timed_out = (TIMEOUT_CYCLES != 0) && (tmr_q == TMR_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    dat_d   = dat_q;
    tmr_d   = tmr_q;
    gap_d   = gap_q;
    grant_d = '0;
    done_d  = '0;
    err_d   = 1'b0;
    start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pick_grant) begin
          state_d = BUSY;
          idx_d   = pick_idx;
          dat_d   = bus.i_dat[int'(pick_idx)*FRAME_W +: FRAME_W];
          grant_d = pick_grant;
          start_d = 1'b1;
          tmr_d   = '0;
        end
      end
      BUSY: begin
        tmr_d = tmr_q + 1'b1;
        // A completion in the timeout cycle still counts as success.
        if (bus.i_sender_finished || timed_out) begin
          done_d  = N_REQ'(1) << idx_q;
          err_d   = !bus.i_sender_finished;
          ptr_d   = (int'(idx_q) == N_REQ - 1) ? '0 : idx_q + 1'b1;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      dat_q   <= '0;
      tmr_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      dat_q   <= dat_d;
      tmr_q   <= tmr_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.o_grant        = grant_q;
  assign bus.o_done         = done_q;
  assign bus.o_err          = err_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_sender_start = start_q;
  assign bus.o_sender_dat   = dat_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter: dut_a (gap 4, timeout 16) and
// dut_b (gap 0, timeout 4096) driven by directed sequences.
module tb_i2c_arbiter;
  import i2c_pkg::*;

  localparam int N  = 2;
  localparam int FW = I2C_FRAME_W;

  typedef struct {
    int             cyc;
    bit             is_done;
    logic [N-1:0]   onehot;
    bit             err;
    bit             busy;
    logic [FW-1:0]  dat;
  } evt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a, rst_b;
  int   checks = 0;
  int   failures = 0;

  evt_t exp_a[$];
  evt_t exp_b[$];
  int   dly_a[$];
  int   dly_b[$];
  int   stray_req_b = 0;

  i2c_arbiter_if #(.N_REQ(N), .FRAME_W(FW)) bus_a ();
  i2c_arbiter_if #(.N_REQ(N), .FRAME_W(FW)) bus_b ();

  i2c_arbiter #(.N_REQ(N), .FRAME_W(FW), .GAP_CYCLES(4), .TIMEOUT_CYCLES(16)) dut_a (
    .i_clk (clk),
    .i_rst (rst_a),
    .bus   (bus_a)
  );

  i2c_arbiter #(.N_REQ(N), .FRAME_W(FW), .GAP_CYCLES(0), .TIMEOUT_CYCLES(4096)) dut_b (
    .i_clk (clk),
    .i_rst (rst_b),
    .bus   (bus_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  function automatic evt_t mk(input int c, input bit d, input logic [N-1:0] oh,
                              input bit err, input bit busy, input logic [FW-1:0] dat);
    evt_t e;
    e.cyc = c; e.is_done = d; e.onehot = oh; e.err = err; e.busy = busy; e.dat = dat;
    return e;
  endfunction

  task automatic compare_evt(input string tag, input evt_t e, input logic [N-1:0] grant,
                             input logic [N-1:0] done, input logic err, input logic busy,
                             input logic start, input logic [FW-1:0] dat);
    check({tag, ".cycle"},      64'(cyc),   64'(e.cyc));
    check({tag, ".grant"},      64'(grant), e.is_done ? 64'd0 : 64'(e.onehot));
    check({tag, ".done"},       64'(done),  e.is_done ? 64'(e.onehot) : 64'd0);
    check({tag, ".start"},      64'(start), 64'(!e.is_done));
    check({tag, ".err"},        64'(err),   64'(e.err));
    check({tag, ".busy"},       64'(busy),  64'(e.busy));
    check({tag, ".sender_dat"}, 64'(dat),   64'(e.dat));
  endtask

  task automatic check_quiet(input string tag, input bit sel_b);
    if (sel_b) begin
      check({tag, ".grant"}, 64'(bus_b.o_grant), 64'd0);
      check({tag, ".done"},  64'(bus_b.o_done),  64'd0);
      check({tag, ".err"},   64'(bus_b.o_err),   64'd0);
      check({tag, ".busy"},  64'(bus_b.o_busy),  64'd0);
      check({tag, ".start"}, 64'(bus_b.o_sender_start), 64'd0);
      check({tag, ".dat"},   64'(bus_b.o_sender_dat),   64'd0);
    end else begin
      check({tag, ".grant"}, 64'(bus_a.o_grant), 64'd0);
      check({tag, ".done"},  64'(bus_a.o_done),  64'd0);
      check({tag, ".err"},   64'(bus_a.o_err),   64'd0);
      check({tag, ".busy"},  64'(bus_a.o_busy),  64'd0);
      check({tag, ".start"}, 64'(bus_a.o_sender_start), 64'd0);
      check({tag, ".dat"},   64'(bus_a.o_sender_dat),   64'd0);
    end
  endtask

  task automatic wait_grant(input bit sel_b, output logic [N-1:0] g);
    g = '0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      g = sel_b ? bus_b.o_grant : bus_a.o_grant;
      if (g != '0) return;
    end
    fail_now(sel_b ? "b.wait_grant" : "a.wait_grant");
  endtask

  task automatic wait_idle(input bit sel_b);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (sel_b ? (!bus_b.o_busy && exp_b.size() == 0) : (!bus_a.o_busy && exp_a.size() == 0))
        return;
    end
    fail_now(sel_b ? "b.wait_idle" : "a.wait_idle");
  endtask

  // Monitors: pop the next expected event whenever a DUT emits grant or done.
  always @(negedge clk) begin
    if (bus_a.o_grant != '0 || bus_a.o_done != '0) begin
      if (exp_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL a.unexpected_event: grant=%b done=%b at cycle %0d, none expected",
                 bus_a.o_grant, bus_a.o_done, cyc);
      end else begin
        compare_evt("a", exp_a.pop_front(), bus_a.o_grant, bus_a.o_done, bus_a.o_err,
                    bus_a.o_busy, bus_a.o_sender_start, bus_a.o_sender_dat);
      end
    end else if (cyc > 0) begin
      check("a.quiet_start_err", 64'({bus_a.o_sender_start, bus_a.o_err}), 64'd0);
    end
  end

  always @(negedge clk) begin
    if (bus_b.o_grant != '0 || bus_b.o_done != '0) begin
      if (exp_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL b.unexpected_event: grant=%b done=%b at cycle %0d, none expected",
                 bus_b.o_grant, bus_b.o_done, cyc);
      end else begin
        compare_evt("b", exp_b.pop_front(), bus_b.o_grant, bus_b.o_done, bus_b.o_err,
                    bus_b.o_busy, bus_b.o_sender_start, bus_b.o_sender_dat);
      end
    end else if (cyc > 0) begin
      check("b.quiet_start_err", 64'({bus_b.o_sender_start, bus_b.o_err}), 64'd0);
    end
  end

  // Sender models: finish d cycles after start; d < 0 means never.
  initial begin : sender_a
    int d;
    bus_a.i_sender_finished = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_a.o_sender_start) begin
        d = (dly_a.size() > 0) ? dly_a.pop_front() : -1;
        if (d > 0) begin
          repeat (d) @(negedge clk);
          bus_a.i_sender_finished = 1'b1;
          @(negedge clk);
          bus_a.i_sender_finished = 1'b0;
        end
      end
    end
  end

  initial begin : sender_b
    int d;
    int stray_seen;
    stray_seen = 0;
    bus_b.i_sender_finished = 1'b0;
    forever begin
      @(negedge clk);
      if (stray_req_b != stray_seen) begin
        stray_seen = stray_req_b;
        bus_b.i_sender_finished = 1'b1;
        @(negedge clk);
        bus_b.i_sender_finished = 1'b0;
      end else if (bus_b.o_sender_start) begin
        d = (dly_b.size() > 0) ? dly_b.pop_front() : -1;
        if (d > 0) begin
          repeat (d) @(negedge clk);
          bus_b.i_sender_finished = 1'b1;
          @(negedge clk);
          bus_b.i_sender_finished = 1'b0;
        end
      end
    end
  end

  localparam logic [FW-1:0] FA0 = 24'h340879;  // build_frame(CODEC_ADDR, 7'h04, 9'h079)
  localparam logic [FW-1:0] FA1 = 24'h350C12;
  localparam logic [FW-1:0] FB0 = 24'h341E00;  // build_frame(CODEC_ADDR, 7'h0F, 9'h000)
  localparam logic [FW-1:0] FB1 = 24'h340C01;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst_a = 1'b1;
    rst_b = 1'b1;
    fork
      begin : thread_a
        int t;
        logic [N-1:0] g;
        bus_a.i_req = '0;
        bus_a.i_dat = {FA1, build_frame(CODEC_ADDR, 7'h04, 9'h079)};
        repeat (3) @(negedge clk);
        check_quiet("a.reset", 1'b0);
        rst_a = 1'b0;
        @(negedge clk);

        // Contention: both requesting, grants alternate with a 4-cycle gap.
        t = cyc;
        bus_a.i_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
          exp_a.push_back(mk(t + 1 + 16*i,  1'b0, (i % 2) ? 2'b10 : 2'b01, 1'b0, 1'b1, (i % 2) ? FA1 : FA0));
          exp_a.push_back(mk(t + 12 + 16*i, 1'b1, (i % 2) ? 2'b10 : 2'b01, 1'b0, 1'b1, (i % 2) ? FA1 : FA0));
          dly_a.push_back(10);
        end
        for (int i = 0; i < 4; i++) begin
          wait_grant(1'b0, g);
          bus_a.i_req = bus_a.i_req & ~g;
          repeat (2) @(negedge clk);
          if (i < 2) bus_a.i_req = bus_a.i_req | g;
        end
        wait_idle(1'b0);

        // Timeout on requester 0, then a finish exactly in the timeout cycle on requester 1.
        t = cyc;
        bus_a.i_req = 2'b11;
        exp_a.push_back(mk(t + 1,  1'b0, 2'b01, 1'b0, 1'b1, FA0));
        exp_a.push_back(mk(t + 17, 1'b1, 2'b01, 1'b1, 1'b1, FA0));
        exp_a.push_back(mk(t + 22, 1'b0, 2'b10, 1'b0, 1'b1, FA1));
        exp_a.push_back(mk(t + 38, 1'b1, 2'b10, 1'b0, 1'b1, FA1));
        dly_a.push_back(-1);
        dly_a.push_back(15);
        for (int i = 0; i < 2; i++) begin
          wait_grant(1'b0, g);
          bus_a.i_req = bus_a.i_req & ~g;
        end
        wait_idle(1'b0);

        // Move the pointer to 1, then reset in the middle of requester 1's transaction.
        t = cyc;
        bus_a.i_req = 2'b01;
        exp_a.push_back(mk(t + 1, 1'b0, 2'b01, 1'b0, 1'b1, FA0));
        exp_a.push_back(mk(t + 7, 1'b1, 2'b01, 1'b0, 1'b1, FA0));
        dly_a.push_back(5);
        wait_grant(1'b0, g);
        bus_a.i_req = '0;
        wait_idle(1'b0);

        t = cyc;
        bus_a.i_req = 2'b10;
        exp_a.push_back(mk(t + 1, 1'b0, 2'b10, 1'b0, 1'b1, FA1));
        dly_a.push_back(-1);
        wait_grant(1'b0, g);
        bus_a.i_req = '0;
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check_quiet("a.mid_reset", 1'b0);

        // Pointer must be back at 0: requester 0 wins a simultaneous request.
        t = cyc;
        bus_a.i_req = 2'b11;
        exp_a.push_back(mk(t + 1, 1'b0, 2'b01, 1'b0, 1'b1, FA0));
        exp_a.push_back(mk(t + 5, 1'b1, 2'b01, 1'b0, 1'b1, FA0));
        dly_a.push_back(3);
        wait_grant(1'b0, g);
        bus_a.i_req = '0;
        wait_idle(1'b0);
      end

      begin : thread_b
        int t;
        logic [N-1:0] g;
        bus_b.i_req = '0;
        bus_b.i_dat = {FB1, build_frame(CODEC_ADDR, 7'h0F, 9'h000)};
        repeat (3) @(negedge clk);
        check_quiet("b.reset", 1'b1);
        rst_b = 1'b0;
        @(negedge clk);

        // Single request, sender finishes 60 cycles after start.
        t = cyc;
        bus_b.i_req = 2'b01;
        exp_b.push_back(mk(t + 1,  1'b0, 2'b01, 1'b0, 1'b1, FB0));
        exp_b.push_back(mk(t + 62, 1'b1, 2'b01, 1'b0, 1'b0, FB0));
        dly_b.push_back(60);
        wait_grant(1'b1, g);
        bus_b.i_req = '0;
        wait_idle(1'b1);

        // Back-to-back with no gap: pointer is 1, next start two cycles after finish.
        t = cyc;
        bus_b.i_req = 2'b11;
        exp_b.push_back(mk(t + 1,  1'b0, 2'b10, 1'b0, 1'b1, FB1));
        exp_b.push_back(mk(t + 7,  1'b1, 2'b10, 1'b0, 1'b0, FB1));
        exp_b.push_back(mk(t + 8,  1'b0, 2'b01, 1'b0, 1'b1, FB0));
        exp_b.push_back(mk(t + 14, 1'b1, 2'b01, 1'b0, 1'b0, FB0));
        dly_b.push_back(5);
        dly_b.push_back(5);
        for (int i = 0; i < 2; i++) begin
          wait_grant(1'b1, g);
          bus_b.i_req = bus_b.i_req & ~g;
        end
        wait_idle(1'b1);

        // Stray finished pulse while idle must not produce a done.
        stray_req_b = stray_req_b + 1;
        repeat (4) @(negedge clk);
        check("b.stray_done", 64'(bus_b.o_done), 64'd0);
        check("b.stray_busy", 64'(bus_b.o_busy), 64'd0);
      end
    join

    repeat (3) @(negedge clk);
    check("a.pending_events", 64'(exp_a.size()), 64'd0);
    check("b.pending_events", 64'(exp_b.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
